// File: rtl/ram_pkg.sv
// ---------------------------------------------------------------------------
// ram_pkg
// Shared types and helpers for the dual-port RAM controller and its storage
// core: clear-sequencer state enum, default byte-lane count, and the
// byte-merge / address range-check functions.
// The helper functions work on a fixed maximum width so that every
// parameterisation can call them. Callers zero-extend their operands into
// that width and truncate the result back to their own width.
// ---------------------------------------------------------------------------
package ram_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } ram_state_e;

  localparam int DATAWIDTH_DEF = 8;
  localparam int BYTEWIDTH_DEF = 8;
  localparam int NUM_BE        = DATAWIDTH_DEF / BYTEWIDTH_DEF;

  // Widest word and widest byte-enable vector the helpers accept.
  localparam int MAX_DW = 64;
  localparam int MAX_BE = 64;

  // Replace each byte of old_w whose enable bit is set with the
  // corresponding byte of new_w. bw is the lane width in bits.
  function automatic logic [MAX_DW-1:0] byte_merge(
    input logic [MAX_DW-1:0] old_w,
    input logic [MAX_DW-1:0] new_w,
    input logic [MAX_BE-1:0] be,
    input int unsigned       bw
  );
    logic [MAX_DW-1:0] res;
    logic [5:0]        bit_idx;
    logic [5:0]        be_idx;
    res = old_w;
    for (int unsigned i = 0; i < MAX_DW; i++) begin
      bit_idx = 6'(i);
      be_idx  = 6'(i / bw);
      if (be[be_idx]) res[bit_idx] = new_w[bit_idx];
    end
    return res;
  endfunction

  // True when addr addresses an existing word of a size-word array.
  function automatic logic in_range(
    input logic [31:0] addr,
    input int unsigned size
  );
    return (addr < size);
  endfunction

endpackage

// File: rtl/ram_core.sv
// ---------------------------------------------------------------------------
// ram_core
// Storage array with one byte-enabled synchronous write port and one
// synchronous read port. The read port is read-first: a read and a write to
// the same word on the same edge return the pre-write contents. The core has
// no reset, and the read register holds its value while re_i is low.
// Ports:
//   clk_i    clock
//   we_i     write enable
//   waddr_i  write address (must be < SIZE when we_i is set)
//   wdata_i  write data
//   be_i     byte enables, bit i covers wdata_i[i*BYTEWIDTH +: BYTEWIDTH]
//   re_i     read enable
//   raddr_i  read address (must be < SIZE when re_i is set)
//   rdata_o  registered read data
// ---------------------------------------------------------------------------
module ram_core
  import ram_pkg::*;
#(
  parameter int ADDRWIDTH = 4,
  parameter int DATAWIDTH = 8,
  parameter int SIZE      = 16,
  parameter int BYTEWIDTH = 8
) (
  input  logic                           clk_i,
  input  logic                           we_i,
  input  logic [ADDRWIDTH-1:0]           waddr_i,
  input  logic [DATAWIDTH-1:0]           wdata_i,
  input  logic [DATAWIDTH/BYTEWIDTH-1:0] be_i,
  input  logic                           re_i,
  input  logic [ADDRWIDTH-1:0]           raddr_i,
  output logic [DATAWIDTH-1:0]           rdata_o
);

  logic [DATAWIDTH-1:0] mem_q [SIZE];
  logic [DATAWIDTH-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= DATAWIDTH'(byte_merge(MAX_DW'(mem_q[waddr_i]), MAX_DW'(wdata_i),
                                              MAX_BE'(be_i), BYTEWIDTH));
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dual_port_ram_ctrl.sv
// ---------------------------------------------------------------------------
// dual_port_ram_ctrl
// Dual-port (one write, one read per cycle) RAM controller with per-byte
// write enables, selectable read-during-write policy, optional output
// register, out-of-range address detection and a post-reset clear sweep.
// Ports:
//   clk        clock, all logic on the rising edge
//   rst_n      asynchronous active-low reset
//   wr_en      write request
//   wr_addr    write address
//   wr_data    write data
//   wr_be      byte enables for wr_data
//   rd_en      read request
//   rd_addr    read address
//   rd_data    read data, holds between valid pulses
//   rd_valid   one-cycle pulse aligned with new rd_data
//   addr_err   one-cycle pulse one cycle after an out-of-range request
//   init_busy  high while the clear sweep runs; requests are ignored
// ---------------------------------------------------------------------------
module dual_port_ram_ctrl
  import ram_pkg::*;
#(
  parameter int ADDRWIDTH      = 4,
  parameter int DATAWIDTH      = 8,
  parameter int SIZE           = 16,
  parameter int BYTEWIDTH      = 8,
  parameter int OUT_REG        = 0,
  parameter int RDW_MODE       = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           wr_en,
  input  logic [ADDRWIDTH-1:0]           wr_addr,
  input  logic [DATAWIDTH-1:0]           wr_data,
  input  logic [DATAWIDTH/BYTEWIDTH-1:0] wr_be,
  input  logic                           rd_en,
  input  logic [ADDRWIDTH-1:0]           rd_addr,
  output logic [DATAWIDTH-1:0]           rd_data,
  output logic                           rd_valid,
  output logic                           addr_err,
  output logic                           init_busy
);

  localparam int BE_W = DATAWIDTH / BYTEWIDTH;

  ram_state_e           state_q, state_d;
  logic [ADDRWIDTH-1:0] cnt_q, cnt_d;
  logic                 busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The counter stops on the last word; only reset brings it back to 0.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_CLEAR: begin
        if (cnt_q == ADDRWIDTH'(SIZE - 1)) begin
          state_d = ST_READY;
        end else begin
          cnt_d = cnt_q + ADDRWIDTH'(1);
        end
      end
      default: ;
    endcase
  end

  assign busy      = (state_q == ST_CLEAR);
  assign init_busy = busy;

  // Request decode: nothing from the ports is accepted while clearing.
  logic wr_in, rd_in, wr_ok, rd_acc, rd_ok, byp_d, err_d;

  assign wr_in  = in_range(32'(wr_addr), SIZE);
  assign rd_in  = in_range(32'(rd_addr), SIZE);
  assign wr_ok  = !busy && wr_en && wr_in;
  assign rd_acc = !busy && rd_en;
  assign rd_ok  = rd_acc && rd_in;
  assign err_d  = !busy && ((wr_en && !wr_in) || (rd_en && !rd_in));
  assign byp_d  = (RDW_MODE != 0) && wr_ok && rd_ok && (wr_addr == rd_addr);

  // The clear sweep owns the core write port while busy.
  logic                 core_we;
  logic [ADDRWIDTH-1:0] core_waddr;
  logic [DATAWIDTH-1:0] core_wdata;
  logic [BE_W-1:0]      core_be;
  logic [DATAWIDTH-1:0] core_rdata;

  assign core_we    = busy || wr_ok;
  assign core_waddr = busy ? cnt_q : wr_addr;
  assign core_wdata = busy ? '0 : wr_data;
  assign core_be    = busy ? '1 : wr_be;

  ram_core #(
    .ADDRWIDTH (ADDRWIDTH),
    .DATAWIDTH (DATAWIDTH),
    .SIZE      (SIZE),
    .BYTEWIDTH (BYTEWIDTH)
  ) u_core (
    .clk_i   (clk),
    .we_i    (core_we),
    .waddr_i (core_waddr),
    .wdata_i (core_wdata),
    .be_i    (core_be),
    .re_i    (rd_ok),
    .raddr_i (rd_addr),
    .rdata_o (core_rdata)
  );

  // ---- stage p1: core read result plus the flags that qualify it ----
  // zero_p1_q forces rd_data to 0 after an out-of-range read; it resets
  // high so rd_data reads 0 before the first real read.
  logic                 vld_p1_q, zero_p1_q, byp_p1_q, err_p1_q;
  logic [DATAWIDTH-1:0] wdata_p1_q;
  logic [BE_W-1:0]      be_p1_q;
  logic [DATAWIDTH-1:0] data_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1_q  <= 1'b0;
      zero_p1_q <= 1'b1;
      byp_p1_q  <= 1'b0;
      err_p1_q  <= 1'b0;
    end else begin
      vld_p1_q <= rd_acc;
      err_p1_q <= err_d;
      if (rd_acc) begin
        zero_p1_q <= !rd_ok;
        byp_p1_q  <= byp_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (byp_d) begin
      wdata_p1_q <= wr_data;
      be_p1_q    <= wr_be;
    end
  end

  // Read-first core data, overlaid with the same-cycle write when bypassing.
  assign data_p1 = zero_p1_q ? '0 :
                   byp_p1_q  ? DATAWIDTH'(byte_merge(MAX_DW'(core_rdata), MAX_DW'(wdata_p1_q),
                                                     MAX_BE'(be_p1_q), BYTEWIDTH)) :
                               core_rdata;

  assign addr_err = err_p1_q;

  // ---- stage p2: optional output register (read path only) ----
  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic                 vld_p2_q;
      logic [DATAWIDTH-1:0] data_p2_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vld_p2_q  <= 1'b0;
          data_p2_q <= '0;
        end else begin
          vld_p2_q <= vld_p1_q;
          if (vld_p1_q) data_p2_q <= data_p1;
        end
      end
      assign rd_valid = vld_p2_q;
      assign rd_data  = data_p2_q;
    end else begin : g_no_out_reg
      assign rd_valid = vld_p1_q;
      assign rd_data  = data_p1;
    end
  endgenerate

endmodule

// File: tb/tb_dual_port_ram_ctrl.sv
// ---------------------------------------------------------------------------
// tb_dual_port_ram_ctrl
// Four controller configurations share one stimulus stream:
//   0: 8-bit,  SIZE 16, no output reg, old-data RDW
//   1: 16-bit, SIZE 16, no output reg, new-data RDW, two byte lanes
//   2: 8-bit,  SIZE 12, no output reg, old-data RDW
//   3: 8-bit,  SIZE 16, output reg,    new-data RDW
// A per-configuration array model predicts every output each cycle, and a
// few literal expectations pin down key values from the test plan.
// ---------------------------------------------------------------------------
module tb_dual_port_ram_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [3:0]  wr_addr = '0;
  logic [15:0] wr_data = '0;
  logic [1:0]  wr_be = '0;
  logic        rd_en = 1'b0;
  logic [3:0]  rd_addr = '0;

  logic [7:0]  rdd0, rdd2, rdd3;
  logic [15:0] rdd1;
  logic [3:0]  vld, err, busy;
  logic [15:0] act_d [4];

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  dual_port_ram_ctrl #(.ADDRWIDTH(4), .DATAWIDTH(8), .SIZE(16), .BYTEWIDTH(8),
    .OUT_REG(0), .RDW_MODE(0), .CLEAR_ON_RESET(1)) u0 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data[7:0]),
    .wr_be(wr_be[0:0]), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rdd0),
    .rd_valid(vld[0]), .addr_err(err[0]), .init_busy(busy[0]));

  dual_port_ram_ctrl #(.ADDRWIDTH(4), .DATAWIDTH(16), .SIZE(16), .BYTEWIDTH(8),
    .OUT_REG(0), .RDW_MODE(1), .CLEAR_ON_RESET(1)) u1 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rdd1),
    .rd_valid(vld[1]), .addr_err(err[1]), .init_busy(busy[1]));

  dual_port_ram_ctrl #(.ADDRWIDTH(4), .DATAWIDTH(8), .SIZE(12), .BYTEWIDTH(8),
    .OUT_REG(0), .RDW_MODE(0), .CLEAR_ON_RESET(1)) u2 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data[7:0]),
    .wr_be(wr_be[0:0]), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rdd2),
    .rd_valid(vld[2]), .addr_err(err[2]), .init_busy(busy[2]));

  dual_port_ram_ctrl #(.ADDRWIDTH(4), .DATAWIDTH(8), .SIZE(16), .BYTEWIDTH(8),
    .OUT_REG(1), .RDW_MODE(1), .CLEAR_ON_RESET(1)) u3 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data[7:0]),
    .wr_be(wr_be[0:0]), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rdd3),
    .rd_valid(vld[3]), .addr_err(err[3]), .init_busy(busy[3]));

  assign act_d[0] = {8'h00, rdd0};
  assign act_d[1] = rdd1;
  assign act_d[2] = {8'h00, rdd2};
  assign act_d[3] = {8'h00, rdd3};

  // ---------------- behavioural model ----------------
  int unsigned SZ_C  [4] = '{16, 16, 12, 16};
  int unsigned NBE_C [4] = '{1, 2, 1, 1};
  int unsigned LAT_C [4] = '{1, 1, 1, 2};
  bit          NEW_C [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

  logic [15:0] mem_m [4][16];
  int unsigned clr_left [4];
  logic [15:0] exp_d [4];
  bit          exp_v [4];
  bit          exp_e [4];
  bit          pend_v [4];
  logic [15:0] pend_d [4];

  // Word after a write of wr_data/wr_be lands on top of w in config k.
  function automatic logic [15:0] written(input int k, input logic [15:0] w);
    logic [15:0] r;
    r = w;
    for (int b = 0; b < 2; b++) begin
      if (b < int'(NBE_C[k]) && wr_be[b]) begin
        r = (r & ~(16'hFF << (8 * b))) | (wr_data & (16'hFF << (8 * b)));
      end
    end
    return r;
  endfunction

  task automatic model_step(input int k);
    bit          v;
    logic [15:0] d;
    bit          e;
    v = 1'b0;
    d = 16'h0;
    e = 1'b0;
    if (clr_left[k] != 0) begin
      mem_m[k][SZ_C[k] - clr_left[k]] = 16'h0;
      clr_left[k] = clr_left[k] - 1;
    end else begin
      e = (wr_en && wr_addr >= SZ_C[k]) || (rd_en && rd_addr >= SZ_C[k]);
      v = rd_en;
      if (rd_en && rd_addr < SZ_C[k]) begin
        d = mem_m[k][rd_addr];
        if (NEW_C[k] && wr_en && wr_addr == rd_addr) d = written(k, d);
      end
      if (wr_en && wr_addr < SZ_C[k]) mem_m[k][wr_addr] = written(k, mem_m[k][wr_addr]);
    end
    exp_e[k] = e;
    if (LAT_C[k] == 1) begin
      exp_v[k] = v;
      if (v) exp_d[k] = d;
    end else begin
      exp_v[k] = pend_v[k];
      if (pend_v[k]) exp_d[k] = pend_d[k];
      pend_v[k] = v;
      pend_d[k] = d;
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < 4; k++) begin
      if (!rst_n) begin
        clr_left[k] = SZ_C[k];
        exp_d[k]    = 16'h0;
        exp_v[k]    = 1'b0;
        exp_e[k]    = 1'b0;
        pend_v[k]   = 1'b0;
        pend_d[k]   = 16'h0;
      end else begin
        model_step(k);
      end
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string nm, input int k, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] at %0t: got %h, want %h", nm, k, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      for (int k = 0; k < 4; k++) begin
        check("init_busy", k, 16'(busy[k]), 16'(clr_left[k] != 0));
        check("rd_valid",  k, 16'(vld[k]),  16'(exp_v[k]));
        check("addr_err",  k, 16'(err[k]),  16'(exp_e[k]));
        check("rd_data",   k, act_d[k],     exp_d[k]);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic we, input logic [3:0] wa, input logic [15:0] wd,
                     input logic [1:0] be, input logic re, input logic [3:0] ra);
    wr_en   = we;
    wr_addr = wa;
    wr_data = wd;
    wr_be   = be;
    rd_en   = re;
    rd_addr = ra;
  endtask

  task automatic idle();
    req(1'b0, 4'd0, 16'h0, 2'b00, 1'b0, 4'd0);
  endtask

  int n;

  initial begin
    idle();
    tick();
    tick();
    chk_on = 1'b1;
    check("lit_reset_busy", 0, 16'(busy[0]), 16'h1);
    check("lit_reset_data", 1, rdd1, 16'h0);

    // Clear sweep length after reset.
    rst_n = 1'b1;
    n = 0;
    while (busy[0] && n < 40) begin
      tick();
      n++;
    end
    check("lit_clear_cycles", 0, 16'(n), 16'd16);

    // Read every address after the sweep.
    for (int a = 0; a < 16; a++) begin
      req(1'b0, 4'd0, 16'h0, 2'b00, 1'b1, 4'(a));
      tick();
      if (a == 0 || a == 15) begin
        check("lit_clr_rd_valid", a, 16'(vld[0]), 16'h1);
        check("lit_clr_rd_data",  a, 16'(rdd0),   16'h0);
      end
    end
    idle();
    tick();

    // Reset in the middle of a sweep, then a write attempt during the new sweep.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (7) tick();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    n = 0;
    while (busy[0] && n < 40) begin
      if (n >= 8 && n <= 10) req(1'b1, 4'd3, 16'h5A5A, 2'b11, 1'b0, 4'd0);
      else idle();
      tick();
      n++;
    end
    idle();
    check("lit_reclear_cycles", 0, 16'(n), 16'd16);
    req(1'b0, 4'd0, 16'h0, 2'b00, 1'b1, 4'd3);
    tick();
    check("lit_busy_write_ignored", 0, 16'(rdd0), 16'h00);

    // Byte enables.
    req(1'b1, 4'd5, 16'hAAAA, 2'b11, 1'b0, 4'd0);
    tick();
    req(1'b1, 4'd5, 16'h1234, 2'b01, 1'b0, 4'd0);
    tick();
    req(1'b0, 4'd0, 16'h0, 2'b00, 1'b1, 4'd5);
    tick();
    check("lit_be_merge16", 1, rdd1, 16'hAA34);
    check("lit_be_merge8",  0, 16'(rdd0), 16'h0034);

    // Read during write at address 2.
    req(1'b1, 4'd2, 16'h0011, 2'b01, 1'b0, 4'd0);
    tick();
    req(1'b1, 4'd2, 16'h0022, 2'b01, 1'b1, 4'd2);
    tick();
    check("lit_rdw_old", 0, 16'(rdd0), 16'h0011);
    check("lit_rdw_new", 1, rdd1,      16'h0022);
    req(1'b0, 4'd0, 16'h0, 2'b00, 1'b1, 4'd2);
    tick();
    check("lit_rdw_after", 0, 16'(rdd0), 16'h0022);

    // Out-of-range accesses against the 12-word configuration.
    req(1'b1, 4'd13, 16'h00FF, 2'b01, 1'b0, 4'd0);
    tick();
    check("lit_oor_wr_err",  2, 16'(err[2]), 16'h1);
    check("lit_inr_wr_err",  0, 16'(err[0]), 16'h0);
    idle();
    tick();
    check("lit_oor_err_pulse", 2, 16'(err[2]), 16'h0);
    req(1'b0, 4'd0, 16'h0, 2'b00, 1'b1, 4'd14);
    tick();
    check("lit_oor_rd_valid", 2, 16'(vld[2]), 16'h1);
    check("lit_oor_rd_data",  2, 16'(rdd2),   16'h0);
    check("lit_oor_rd_err",   2, 16'(err[2]), 16'h1);
    req(1'b1, 4'd12, 16'h0077, 2'b01, 1'b1, 4'd15);
    tick();
    check("lit_oor_both_err", 2, 16'(err[2]), 16'h1);
    for (int a = 0; a < 12; a++) begin
      req(1'b0, 4'd0, 16'h0, 2'b00, 1'b1, 4'(a));
      tick();
    end
    idle();
    tick();

    // Output-register pipeline with back-to-back reads.
    req(1'b1, 4'd0, 16'h0010, 2'b01, 1'b0, 4'd0);
    tick();
    req(1'b1, 4'd1, 16'h0020, 2'b01, 1'b0, 4'd0);
    tick();
    req(1'b1, 4'd2, 16'h0030, 2'b01, 1'b0, 4'd0);
    tick();
    idle();
    tick();
    req(1'b0, 4'd0, 16'h0, 2'b00, 1'b1, 4'd0);
    tick();
    check("lit_or_lat_v0", 3, 16'(vld[3]), 16'h0);
    req(1'b0, 4'd0, 16'h0, 2'b00, 1'b1, 4'd1);
    tick();
    check("lit_or_v1", 3, 16'(vld[3]), 16'h1);
    check("lit_or_d1", 3, 16'(rdd3),   16'h0010);
    req(1'b0, 4'd0, 16'h0, 2'b00, 1'b1, 4'd2);
    tick();
    check("lit_or_d2", 3, 16'(rdd3), 16'h0020);
    idle();
    tick();
    check("lit_or_d3", 3, 16'(rdd3), 16'h0030);
    tick();
    check("lit_or_hold_v", 3, 16'(vld[3]), 16'h0);
    check("lit_or_hold_d", 3, 16'(rdd3),   16'h0030);

    // Mixed traffic, checked cycle by cycle against the model.
    for (int i = 0; i < 200; i++) begin
      req(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 16'($urandom_range(0, 65535)),
          2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
      if (i % 7 == 0) rd_addr = wr_addr;
      tick();
    end
    idle();
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dual_port_ram_ctrl.md
Name: dual_port_ram_ctrl

Overview:
- Parametrised successor to the single-port RAM core, for use behind the pad ring.
- Separates the shared bidirectional data bus into independent write and read ports, so one write and one read can happen in the same cycle.
- Adds per-byte write enables, a selectable read-during-write policy, an optional output register, out-of-range address detection, and a post-reset memory-clear sequencer.

Parameters:
- ADDRWIDTH, 4: address width of both ports.
- DATAWIDTH, 8: word width; must be a multiple of BYTEWIDTH.
- SIZE, 16: number of words; must be ≤ 2**ADDRWIDTH.
- BYTEWIDTH, 8: bits controlled by each wr_be bit.
- OUT_REG, 0: 1 adds an output pipeline stage, so read latency is 2 instead of 1.
- RDW_MODE, 0: same-address read-during-write policy; 0 returns old data, 1 returns new (byte-merged) data.
- CLEAR_ON_RESET, 1: 1 zeroes the whole array after reset before accepting requests.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- wr_en  input  1  write request.
- wr_addr  input  ADDRWIDTH  write address.
- wr_data  input  DATAWIDTH  write data.
- wr_be  input  DATAWIDTH/BYTEWIDTH  byte enables; bit i covers wr_data[i*BYTEWIDTH +: BYTEWIDTH].
- rd_en  input  1  read request.
- rd_addr  input  ADDRWIDTH  read address.
- rd_data  output  DATAWIDTH  read data; holds its value between valids.
- rd_valid  output  1  one-cycle pulse, aligned with new rd_data.
- addr_err  output  1  one-cycle pulse, one cycle after an accepted request with address ≥ SIZE.
- init_busy  output  1  high while the clear sequencer runs; requests are ignored while high.

Behaviour:
- Reset values (while rst_n low):
  - rd_data = 0, rd_valid = 0, addr_err = 0.
  - init_busy = CLEAR_ON_RESET.
  - FSM state = CLEAR if CLEAR_ON_RESET, else READY; clear counter = 0.
- The array itself is not asynchronously reset.
- FSM states:
  - CLEAR: writes 0 to address cnt each cycle, cnt increments. At cnt == SIZE-1 it writes, then moves to READY. Total SIZE cycles with init_busy high.
  - READY: init_busy = 0; services requests.
  - No other states. No transition back to CLEAR except via rst_n.
- Reset asserted mid-CLEAR aborts the sweep; after release it restarts from address 0.
- During CLEAR, wr_en and rd_en are ignored: no array update from the write port, no rd_valid, no addr_err.
- Write (READY, wr_en = 1, wr_addr < SIZE): on the clock edge, mem[wr_addr] byte i ← wr_data byte i for each set wr_be[i]; other bytes unchanged. wr_be = 0 is a legal no-op (no error).
- Read (READY, rd_en = 1, rd_addr < SIZE):
  - OUT_REG = 0: rd_data and rd_valid update at edge N+1 for a request sampled at edge N (latency 1).
  - OUT_REG = 1: latency 2.
  - Back-to-back reads every cycle are supported at full throughput.
- Same-address write and read in the same cycle:
  - RDW_MODE = 0: rd_data = pre-write contents.
  - RDW_MODE = 1: rd_data = pre-write contents with enabled bytes replaced by wr_data.
  - Different addresses: fully independent.
- Out of range (address ≥ SIZE):
  - Write: dropped, array unchanged.
  - Read: rd_valid still pulses with rd_data = 0, at the same latency.
  - addr_err pulses once if either port or both are out of range. With OUT_REG = 1, addr_err keeps latency 1 and is not delayed.
- rd_en = 0: rd_valid = 0 and rd_data retains its last value.
- With SIZE = 2**ADDRWIDTH, addr_err never fires. The clear counter wraps to 0 only via reset.

Decomposition:
- Shared package ram_pkg holds:
  - the FSM state enum (CLEAR, READY);
  - localparam NUM_BE = DATAWIDTH/BYTEWIDTH;
  - functions for byte-merge and range check.
- One sub-module, ram_core: storage array, byte-enabled synchronous write, synchronous read, no reset.
- dual_port_ram_ctrl contains:
  - the clear FSM;
  - muxing of the clear write onto the ram_core write port;
  - RDW bypass logic;
  - the optional output stage;
  - error detection.

Test Plan:
- Reset then CLEAR_ON_RESET = 1, SIZE = 16: init_busy high for exactly 16 cycles after rst_n rises. Then read all 16 addresses → each rd_data = 0x00, rd_valid one cycle after rd_en.
- Reset mid-clear: assert rst_n low at clear cycle 7 and release → init_busy stays high for a fresh 16 cycles. wr_en at address 3 during CLEAR is ignored (address 3 still reads 0x00).
- Byte enables, DATAWIDTH = 16: write 0xAAAA with wr_be = 2'b11 to address 5, then 0x1234 with wr_be = 2'b01 → read address 5 gives 0xAA34.
- Read-during-write at address 2 (old contents 0x11, write 0x22, wr_be = 1):
  - RDW_MODE = 0 → rd_data = 0x11, then the next read gives 0x22.
  - RDW_MODE = 1 → rd_data = 0x22.
- SIZE = 12, ADDRWIDTH = 4:
  - Write 0xFF to address 13 → addr_err pulses 1 cycle later, no array change.
  - Read address 14 → rd_valid pulses with rd_data = 0x00, addr_err pulses.
- OUT_REG = 1: reads of addresses 0, 1, 2 on consecutive cycles (contents 0x10, 0x20, 0x30) → rd_valid high for 3 consecutive cycles starting 2 cycles after the first rd_en, with data 0x10, 0x20, 0x30.
